// File: rtl/elevator_car_controller.sv
// Single-car, four-floor elevator controller: latches hall calls into a pending
// bitmap and sequences the car between travel, door service and idle.
module elevator_car_controller #(
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] floor_call,
    input  logic       up_down_flag,
    output logic [1:0] current_floor,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic [3:0] pending,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_e;

    localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] floor_q, floor_d;
    logic [3:0] pending_q, pending_d;
    logic [7:0] timer_q, timer_d;
    logic       pref_up_q, pref_up_d;
    logic       motor_up_q, motor_down_q, door_open_q;

    logic       call_valid;
    logic [1:0] call_floor;
    logic       door_hold;
    logic [3:0] set_vec, clr_vec, pend_seen;
    logic [1:0] next_floor;
    logic [3:0] above_cur, below_cur, above_next, below_next;

    always_comb begin
        call_valid = (floor_call[2] == 1'b0);
        call_floor = floor_call[1:0];
        door_hold  = call_valid && (state_q == DOOR_OPEN) && (call_floor == floor_q);

        set_vec = '0;
        if (call_valid && !door_hold) begin
            set_vec[call_floor] = 1'b1;
        end
        // Arrival decisions see calls landing on the same edge.
        pend_seen = pending_q | set_vec;

        next_floor = (state_q == MOVE_UP) ? floor_q + 2'd1 : floor_q - 2'd1;
        above_cur  = 4'b1110 << floor_q;
        below_cur  = (4'b0001 << floor_q) - 4'd1;
        above_next = 4'b1110 << next_floor;
        below_next = (4'b0001 << next_floor) - 4'd1;

        pref_up_d = call_valid ? up_down_flag : pref_up_q;
        clr_vec   = '0;
        state_d   = state_q;
        floor_d   = floor_q;
        timer_d   = timer_q;

        unique case (state_q)
            IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d          = DOOR_OPEN;
                    clr_vec[floor_q] = 1'b1;
                    timer_d          = DOOR_LOAD;
                end else if (|(pending_q & above_cur) && |(pending_q & below_cur)) begin
                    state_d = pref_up_q ? MOVE_UP : MOVE_DOWN;
                    timer_d = TRAVEL_LOAD;
                end else if (|(pending_q & above_cur)) begin
                    state_d = MOVE_UP;
                    timer_d = TRAVEL_LOAD;
                end else if (|(pending_q & below_cur)) begin
                    state_d = MOVE_DOWN;
                    timer_d = TRAVEL_LOAD;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (timer_q != 8'd0) begin
                    timer_d = timer_q - 8'd1;
                end else begin
                    floor_d = next_floor;
                    if (pend_seen[next_floor]) begin
                        state_d             = DOOR_OPEN;
                        clr_vec[next_floor] = 1'b1;
                        timer_d             = DOOR_LOAD;
                    end else if ((state_q == MOVE_UP)   && |(pend_seen & above_next) ||
                                 (state_q == MOVE_DOWN) && |(pend_seen & below_next)) begin
                        timer_d = TRAVEL_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                if (door_hold) begin
                    timer_d = DOOR_LOAD;
                end else if (timer_q != 8'd0) begin
                    timer_d = timer_q - 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = (pending_q | set_vec) & ~clr_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            floor_q      <= '0;
            pending_q    <= '0;
            timer_q      <= '0;
            pref_up_q    <= 1'b1;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            pending_q    <= pending_d;
            timer_q      <= timer_d;
            pref_up_q    <= pref_up_d;
            motor_up_q   <= (state_d == MOVE_UP);
            motor_down_q <= (state_d == MOVE_DOWN);
            door_open_q  <= (state_d == DOOR_OPEN);
        end
    end

    assign current_floor = floor_q;
    assign motor_up      = motor_up_q;
    assign motor_down    = motor_down_q;
    assign door_open     = door_open_q;
    assign pending       = pending_q;
    assign state         = state_q;

endmodule

// File: tb/tb_elevator_car_controller.sv
// Directed bench for elevator_car_controller: vector table of call/wait steps
// with expected outputs, plus hand sequences for asynchronous reset.
module tb_elevator_car_controller;

    localparam logic [1:0] S_IDLE = 2'd0, S_UP = 2'd1, S_DN = 2'd2, S_DOOR = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] floor_call = 3'd4;
    logic       up_down_flag = 1'b1;
    logic [1:0] current_floor;
    logic       motor_up, motor_down, door_open;
    logic [3:0] pending;
    logic [1:0] state;

    int unsigned checks = 0;
    int unsigned passes = 0;

    elevator_car_controller #(.TRAVEL_CYCLES(8), .DOOR_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .floor_call   (floor_call),
        .up_down_flag (up_down_flag),
        .current_floor(current_floor),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .door_open    (door_open),
        .pending      (pending),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  call;
        logic        up;
        int unsigned n;
        logic [1:0]  st;
        logic [1:0]  fl;
        logic [3:0]  pend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [2:0] c, logic u, int unsigned n,
                                logic [1:0] st, logic [1:0] fl, logic [3:0] p);
        vec_t v;
        v.rst = r; v.call = c; v.up = u; v.n = n; v.st = st; v.fl = fl; v.pend = p;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [10:0] outs();
        return {state, current_floor, pending, motor_up, motor_down, door_open};
    endfunction

    function automatic logic [10:0] want(logic [1:0] st, logic [1:0] fl, logic [3:0] p);
        return {st, fl, p, st == S_UP, st == S_DN, st == S_DOOR};
    endfunction

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        floor_call = 3'd4;
        rst_n = 1'b0;
        #1;
        chk(name, 32'(outs()), 32'(want(S_IDLE, 2'd0, 4'b0000)));
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
    endtask

    // Running invariants: one actuator at a time, no direct motor reversal.
    logic prev_mu = 1'b0, prev_md = 1'b0;
    always @(negedge clk) begin
        chk("onehot_actuators", 32'($countones({motor_up, motor_down, door_open}) <= 1), 32'd1);
        chk("no_direct_reversal", 32'((prev_mu && motor_down) || (prev_md && motor_up)), 32'd0);
        prev_mu <= motor_up;
        prev_md <= motor_down;
    end

    initial begin
        // Car at 0: self-floor call opens door, no motion.
        tbl.push_back(mk(1, 4, 1, 0, S_IDLE, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 1, 1, S_IDLE, 0, 4'b0001));
        tbl.push_back(mk(0, 4, 1, 1, S_DOOR, 0, 4'b0000));
        tbl.push_back(mk(0, 4, 1, 3, S_DOOR, 0, 4'b0000));
        tbl.push_back(mk(0, 4, 1, 1, S_IDLE, 0, 4'b0000));
        // Single call to floor 2: 8 cycles per floor, 4-cycle door.
        tbl.push_back(mk(0, 2, 1, 1, S_IDLE, 0, 4'b0100));
        tbl.push_back(mk(0, 4, 1, 1, S_UP,   0, 4'b0100));
        tbl.push_back(mk(0, 4, 1, 7, S_UP,   0, 4'b0100));
        tbl.push_back(mk(0, 4, 1, 1, S_UP,   1, 4'b0100));
        tbl.push_back(mk(0, 4, 1, 7, S_UP,   1, 4'b0100));
        tbl.push_back(mk(0, 4, 1, 1, S_DOOR, 2, 4'b0000));
        tbl.push_back(mk(0, 4, 1, 3, S_DOOR, 2, 4'b0000));
        tbl.push_back(mk(0, 4, 1, 1, S_IDLE, 2, 4'b0000));
        // Codes 5..7 ignored; door reopen call at floor 2 reloads the timer.
        tbl.push_back(mk(0, 6, 1, 2, S_IDLE, 2, 4'b0000));
        tbl.push_back(mk(0, 7, 0, 1, S_IDLE, 2, 4'b0000));
        tbl.push_back(mk(0, 2, 1, 1, S_IDLE, 2, 4'b0100));
        tbl.push_back(mk(0, 4, 1, 1, S_DOOR, 2, 4'b0000));
        tbl.push_back(mk(0, 4, 1, 2, S_DOOR, 2, 4'b0000));
        tbl.push_back(mk(0, 2, 1, 1, S_DOOR, 2, 4'b0000));
        tbl.push_back(mk(0, 4, 1, 3, S_DOOR, 2, 4'b0000));
        tbl.push_back(mk(0, 4, 1, 1, S_IDLE, 2, 4'b0000));
        // Car at 1, calls 3 and 0 during door, last flag down: down first.
        tbl.push_back(mk(1, 4, 1, 0, S_IDLE, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 1, 1, S_IDLE, 0, 4'b0010));
        tbl.push_back(mk(0, 4, 1, 1, S_UP,   0, 4'b0010));
        tbl.push_back(mk(0, 4, 1, 7, S_UP,   0, 4'b0010));
        tbl.push_back(mk(0, 4, 1, 1, S_DOOR, 1, 4'b0000));
        tbl.push_back(mk(0, 3, 1, 1, S_DOOR, 1, 4'b1000));
        tbl.push_back(mk(0, 0, 0, 1, S_DOOR, 1, 4'b1001));
        tbl.push_back(mk(0, 4, 1, 1, S_DOOR, 1, 4'b1001));
        tbl.push_back(mk(0, 4, 1, 1, S_IDLE, 1, 4'b1001));
        tbl.push_back(mk(0, 4, 1, 1, S_DN,   1, 4'b1001));
        tbl.push_back(mk(0, 4, 1, 7, S_DN,   1, 4'b1001));
        tbl.push_back(mk(0, 4, 1, 1, S_DOOR, 0, 4'b1000));
        tbl.push_back(mk(0, 4, 1, 3, S_DOOR, 0, 4'b1000));
        tbl.push_back(mk(0, 4, 1, 1, S_IDLE, 0, 4'b1000));
        tbl.push_back(mk(0, 4, 1, 1, S_UP,   0, 4'b1000));
        tbl.push_back(mk(0, 4, 1, 8, S_UP,   1, 4'b1000));
        tbl.push_back(mk(0, 4, 1, 8, S_UP,   2, 4'b1000));
        tbl.push_back(mk(0, 4, 1, 8, S_DOOR, 3, 4'b0000));
        tbl.push_back(mk(0, 4, 1, 4, S_IDLE, 3, 4'b0000));
        // Moving 0->3, call 2 mid-travel: stop at 2, then resume.
        tbl.push_back(mk(1, 4, 1, 0, S_IDLE, 0, 4'b0000));
        tbl.push_back(mk(0, 3, 1, 1, S_IDLE, 0, 4'b1000));
        tbl.push_back(mk(0, 4, 1, 1, S_UP,   0, 4'b1000));
        tbl.push_back(mk(0, 4, 1, 8, S_UP,   1, 4'b1000));
        tbl.push_back(mk(0, 2, 1, 1, S_UP,   1, 4'b1100));
        tbl.push_back(mk(0, 4, 1, 6, S_UP,   1, 4'b1100));
        tbl.push_back(mk(0, 4, 1, 1, S_DOOR, 2, 4'b1000));
        tbl.push_back(mk(0, 4, 1, 3, S_DOOR, 2, 4'b1000));
        tbl.push_back(mk(0, 4, 1, 1, S_IDLE, 2, 4'b1000));
        tbl.push_back(mk(0, 4, 1, 1, S_UP,   2, 4'b1000));
        tbl.push_back(mk(0, 4, 1, 8, S_DOOR, 3, 4'b0000));
        tbl.push_back(mk(0, 4, 1, 4, S_IDLE, 3, 4'b0000));
        // Going down, call 2 lands on the arrival edge: stop there, clear wins.
        tbl.push_back(mk(0, 0, 0, 1, S_IDLE, 3, 4'b0001));
        tbl.push_back(mk(0, 4, 1, 1, S_DN,   3, 4'b0001));
        tbl.push_back(mk(0, 4, 1, 7, S_DN,   3, 4'b0001));
        tbl.push_back(mk(0, 2, 0, 1, S_DOOR, 2, 4'b0001));
        tbl.push_back(mk(0, 4, 1, 3, S_DOOR, 2, 4'b0001));
        tbl.push_back(mk(0, 4, 1, 1, S_IDLE, 2, 4'b0001));
        tbl.push_back(mk(0, 4, 1, 1, S_DN,   2, 4'b0001));
        tbl.push_back(mk(0, 4, 1, 8, S_DN,   1, 4'b0001));
        tbl.push_back(mk(0, 4, 1, 8, S_DOOR, 0, 4'b0000));
        tbl.push_back(mk(0, 4, 1, 4, S_IDLE, 0, 4'b0000));

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                do_reset($sformatf("vec%0d_reset", i));
            end else begin
                floor_call   = tbl[i].call;
                up_down_flag = tbl[i].up;
                step(tbl[i].n);
                floor_call = 3'd4;
                chk($sformatf("vec%0d", i), 32'(outs()),
                    32'(want(tbl[i].st, tbl[i].fl, tbl[i].pend)));
            end
        end

        // Reset pulsed mid-cycle while moving between floors 1 and 2.
        do_reset("pre_async_reset");
        floor_call = 3'd3; up_down_flag = 1'b1;
        step(1);
        floor_call = 3'd4;
        step(12);
        chk("moving_before_reset", 32'(outs()), 32'(want(S_UP, 2'd1, 4'b1000)));
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_now", 32'(outs()), 32'(want(S_IDLE, 2'd0, 4'b0000)));
        floor_call = 3'd2;
        repeat (2) @(posedge clk);
        #1;
        chk("held_in_reset", 32'(outs()), 32'(want(S_IDLE, 2'd0, 4'b0000)));
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        floor_call = 3'd4;
        chk("first_edge_call", 32'(outs()), 32'(want(S_IDLE, 2'd0, 4'b0100)));
        step(1);
        chk("first_edge_move", 32'(outs()), 32'(want(S_UP, 2'd0, 4'b0100)));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/elevator_car_controller.md
ELEVATOR_CAR_CONTROLLER -- requirements
Module: elevator_car_controller

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 8: clock cycles to move one floor (legal 2..255).
REQ-002 Parameter DOOR_CYCLES, default 4: clock cycles door stays open per service (legal 2..255).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 floor_call  input  3  encoded hall call from the button stage; 0..3 = floor, 4 = no call, 5..7 treated as no call.
REQ-006 up_down_flag  input  1  1 = requested travel up, 0 = down; qualified by floor_call <= 3.
REQ-007 current_floor  output  2  registered car position, 0..3.
REQ-008 motor_up  output  1  registered; high exactly while state = MOVE_UP.
REQ-009 motor_down  output  1  registered; high exactly while state = MOVE_DOWN.
REQ-010 door_open  output  1  registered; high exactly while state = DOOR_OPEN.
REQ-011 pending  output  4  registered outstanding-call bitmap, bit n = floor n.
REQ-012 state  output  2  IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=3.

Function
REQ-013 Call latch: each cycle with floor_call <= 3, pending[floor_call] SHALL set at next edge; up_down_flag captured into internal pref_up at same edge.
REQ-014 Exception: floor_call == current_floor while DOOR_OPEN SHALL NOT set pending; it SHALL reload the door timer to DOOR_CYCLES-1.
REQ-015 Set/clear collision on same bit in same cycle: clear (service) SHALL win.
REQ-016 IDLE, pending[current_floor]=1: next state DOOR_OPEN, clear that bit, load door timer DOOR_CYCLES-1.
REQ-017 IDLE, only calls above: MOVE_UP; only calls below: MOVE_DOWN; both: MOVE_UP if pref_up=1 else MOVE_DOWN; none: stay IDLE.
REQ-018 REQ-016 has priority over REQ-017.
REQ-019 Entering MOVE_*: travel timer loaded TRAVEL_CYCLES-1; decrements each cycle in MOVE_*.
REQ-020 Timer = 0 in MOVE_UP/MOVE_DOWN: current_floor SHALL increment/decrement by 1 at that edge, giving exactly TRAVEL_CYCLES cycles per floor.
REQ-021 On arrival at floor f: pending[f]=1 -> DOOR_OPEN, clear bit, load door timer; else calls remain beyond f in same direction -> stay in MOVE_*, reload travel timer; else -> IDLE.
REQ-022 Arrival decision SHALL use pending value including a set landing in the arrival cycle.
REQ-023 current_floor SHALL never pass 3 or go below 0; MOVE_UP at floor 3 or MOVE_DOWN at floor 0 never entered.
REQ-024 DOOR_OPEN: door timer decrements each cycle; at 0 -> IDLE; door_open high exactly DOOR_CYCLES cycles absent REQ-014 reloads.
REQ-025 Direction reversal SHALL only occur via IDLE (at least one IDLE cycle between MOVE_UP and MOVE_DOWN).
REQ-026 motor_up, motor_down, door_open SHALL be mutually exclusive in every cycle.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, current_floor=0, pending=0000, all motor/door outputs 0, timers 0, pref_up=1, independent of clk.
REQ-028 Reset asserted mid-move or mid-door SHALL abandon the operation; no call survives reset.
REQ-029 First call SHALL be latched on the first rising edge after rst_n deasserts.

Verification
REQ-030 Reset, floor_call=2 for one cycle -> pending=0100 next edge, motor_up next cycle, current_floor=1 after 8 cycles, 2 after 16, then door_open 4 cycles, pending=0000, IDLE.
REQ-031 Car at 0 in IDLE, floor_call=0 -> pending bit0 set, DOOR_OPEN next cycle for 4 cycles, motor outputs never asserted.
REQ-032 Car at 2 DOOR_OPEN, floor_call=2 at door cycle 3 -> door_open extended to 4 cycles from that call, pending stays 0000.
REQ-033 Car at 1 IDLE, calls 3 and 0 same cycle window, last up_down_flag=0 -> MOVE_DOWN to 0, door, IDLE, then MOVE_UP to 3.
REQ-034 Car moving 0->3 (call 3), floor_call=2 issued before arrival at 2 -> car stops at 2 (door 4 cycles), then IDLE, then resumes to 3.
REQ-035 rst_n pulsed low during MOVE_UP between floors 1 and 2 -> all outputs at reset values asynchronously, current_floor=0, pending=0000.
